// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller
// for the MEM stage. 32 lines x 32 bytes (1 KiB).
// Address split: tag = addr[31:10], index = addr[9:5], word = addr[4:2].
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-low reset
//   cpu_read_i/write_i    load/store request (both high = store)
//   cpu_addr_i/wdata_i    byte address (word aligned) and store data
//   cpu_rdata_o           load data, valid while cpu_stall_o = 0
//   cpu_stall_o           MemStall to the pipeline registers
//   mem_enable_o          memory request valid
//   mem_write_o           1 = line write-back, 0 = line fetch
//   mem_addr_o            line-aligned memory address
//   mem_wdata_o           victim line for write-back
//   mem_rdata_i           fetched line, valid with mem_ack_i
//   mem_ack_i             one-cycle completion pulse
//   dbg_state_o           current FSM state (0 IDLE, 1 WRITEBACK, 2 ALLOCATE)
//
// Memory handshake: mem_enable_o is raised on the edge that enters WRITEBACK
// or ALLOCATE and held, together with mem_write_o, mem_addr_o and
// mem_wdata_o, until the cycle in which mem_ack_i is sampled high; the
// following edge drops the request or switches it to the next transaction.
module dcache_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_read_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic [255:0] mem_rdata_i,
  input  logic         mem_ack_i,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_e;

  state_e         state_q;
  logic           mem_en_q;
  logic           mem_wr_q;
  logic [31:0]    valid_q;
  logic [31:0]    dirty_q;
  logic [21:0]    tag_q  [32];
  logic [255:0]   data_q [32];

  logic [21:0]    req_tag;
  logic [4:0]     idx;
  logic [7:0]     bit_ofs;
  logic           req;
  logic           hit;
  logic           victim_dirty;
  logic [255:0]   line;
  logic           unused_addr_lsb;

  assign req_tag      = cpu_addr_i[31:10];
  assign idx          = cpu_addr_i[9:5];
  assign bit_ofs      = {cpu_addr_i[4:2], 5'b0};
  assign req          = cpu_read_i | cpu_write_i;
  assign hit          = req & valid_q[idx] & (tag_q[idx] == req_tag);
  assign victim_dirty = valid_q[idx] & dirty_q[idx];
  assign line         = data_q[idx];
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  // Control FSM; valid/dirty live here because they are the only array
  // state that reset must clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      valid_q  <= '0;
      dirty_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req && !hit) begin
            mem_en_q <= 1'b1;
            if (victim_dirty) begin
              state_q  <= S_WRITEBACK;
              mem_wr_q <= 1'b1;
            end else begin
              state_q  <= S_ALLOCATE;
              mem_wr_q <= 1'b0;
            end
          end else if (hit && cpu_write_i) begin
            dirty_q[idx] <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            state_q  <= S_ALLOCATE;
            mem_wr_q <= 1'b0;
          end
        end
        S_ALLOCATE: begin
          if (mem_ack_i) begin
            state_q      <= S_IDLE;
            mem_en_q     <= 1'b0;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          mem_en_q <= 1'b0;
          mem_wr_q <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays are not reset. Updates are gated by state_q, which
  // reset forces to IDLE, so an abandoned fill never lands in the array.
  always_ff @(posedge clk_i) begin
    if (state_q == S_ALLOCATE && mem_ack_i) begin
      data_q[idx] <= mem_rdata_i;
      tag_q[idx]  <= req_tag;
    end else if (state_q == S_IDLE && hit && cpu_write_i) begin
      data_q[idx][bit_ofs +: 32] <= cpu_wdata_i;
    end
  end

  assign cpu_stall_o  = (state_q != S_IDLE) | (req & ~hit);
  assign cpu_rdata_o  = hit ? line[bit_ofs +: 32] : 32'h0;
  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_wr_q;
  assign mem_addr_o   = (state_q == S_WRITEBACK) ? {tag_q[idx], idx, 5'b0}
                                                  : {req_tag, idx, 5'b0};
  assign mem_wdata_o  = line;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic         clk;
  logic         rst_i;
  logic         cpu_read_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;
  logic [1:0]   dbg_state_o;

  int checks = 0;
  int failures = 0;

  dcache_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cpu_read_i   (cpu_read_i),
    .cpu_write_i  (cpu_write_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .dbg_state_o  (dbg_state_o)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Off-chip memory stub: every word holds its own address xor a constant.
  function automatic logic [31:0] word_pat(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [255:0] line_pat(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) begin
      l[w*32 +: 32] = word_pat({a[31:5], w[2:0], 2'b00});
    end
    return l;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          exp_stall;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_wb;
    logic [31:0] wb_addr;
    int          wb_off;
    logic [31:0] wb_word;
    logic        exp_fill;
    logic [31:0] fill_addr;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat, input int exp_stall,
                              input logic chk_rd, input logic [31:0] exp_rd,
                              input logic exp_wb, input logic [31:0] wb_addr, input int wb_off,
                              input logic [31:0] wb_word, input logic exp_fill,
                              input logic [31:0] fill_addr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.lat = lat;
    v.exp_stall = exp_stall; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    v.exp_wb = exp_wb; v.wb_addr = wb_addr; v.wb_off = wb_off; v.wb_word = wb_word;
    v.exp_fill = exp_fill; v.fill_addr = fill_addr;
    return v;
  endfunction

  // Driver + memory responder for one CPU access. Inputs change #1 after the
  // rising edge; outputs are sampled on the falling edge.
  task automatic do_access(input string nm, input vec_t v);
    int          stall_n = 0;
    int          wait_n = 0;
    int          guard = 0;
    bit          done = 0;
    bit          acked;
    logic        saw_wb = 0;
    logic        saw_fill = 0;
    logic        order_bad = 0;
    logic [31:0] wb_a = '0;
    logic [31:0] fill_a = '0;
    logic [31:0] rd = '0;
    logic [255:0] wb_d = '0;
    cpu_read_i  = v.rd;
    cpu_write_i = v.wr;
    cpu_addr_i  = v.addr;
    cpu_wdata_i = v.wdata;
    mem_ack_i   = 1'b0;
    while (!done && guard < 200) begin
      guard++;
      acked = 0;
      @(negedge clk);
      if (!cpu_stall_o) begin
        rd = cpu_rdata_o;
        done = 1;
      end else begin
        stall_n++;
        if (mem_enable_o) begin
          wait_n++;
          if (mem_write_o) begin
            saw_wb = 1'b1;
            wb_a = mem_addr_o;
            wb_d = mem_wdata_o;
            if (saw_fill) order_bad = 1'b1;
          end else begin
            saw_fill = 1'b1;
            fill_a = mem_addr_o;
          end
          if (wait_n >= v.lat) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = mem_write_o ? 256'h0 : line_pat(mem_addr_o);
            acked = 1;
          end
        end
        @(posedge clk);
        #1;
        mem_ack_i = 1'b0;
        if (acked) wait_n = 0;
      end
    end
    if (!done) begin
      failures++;
      $display("FAIL %s/timeout actual=stalled expected=done within 200 cycles", nm);
    end
    @(posedge clk);
    #1;
    cpu_read_i  = 1'b0;
    cpu_write_i = 1'b0;
    check({nm, "/stall"}, stall_n, v.exp_stall);
    if (v.chk_rd) check({nm, "/rdata"}, rd, v.exp_rd);
    check({nm, "/wb_seen"}, {31'd0, saw_wb}, {31'd0, v.exp_wb});
    if (v.exp_wb) begin
      check({nm, "/wb_addr"}, wb_a, v.wb_addr);
      check({nm, "/wb_word"}, wb_d[v.wb_off*32 +: 32], v.wb_word);
    end
    check({nm, "/fill_seen"}, {31'd0, saw_fill}, {31'd0, v.exp_fill});
    if (v.exp_fill) check({nm, "/fill_addr"}, fill_a, v.fill_addr);
    check({nm, "/wb_before_fill"}, {31'd0, order_bad}, 32'd0);
  endtask

  vec_t tbl[13];

  initial begin
    // table: rd wr addr wdata lat stall chk_rd exp_rd wb wb_addr wb_off wb_word fill fill_addr
    tbl[0]  = mk(1, 0, 32'h24,  0,            3, 4, 1, word_pat(32'h24),  0, 0,      0, 0,            1, 32'h20);
    tbl[1]  = mk(1, 0, 32'h24,  0,            1, 0, 1, word_pat(32'h24),  0, 0,      0, 0,            0, 0);
    tbl[2]  = mk(0, 1, 32'h28,  32'hDEADBEEF, 1, 0, 0, 0,                 0, 0,      0, 0,            0, 0);
    tbl[3]  = mk(1, 0, 32'h28,  0,            1, 0, 1, 32'hDEADBEEF,      0, 0,      0, 0,            0, 0);
    tbl[4]  = mk(1, 0, 32'h428, 0,            2, 5, 1, word_pat(32'h428), 1, 32'h20, 2, 32'hDEADBEEF, 1, 32'h420);
    tbl[5]  = mk(0, 1, 32'h44,  32'h12345678, 1, 2, 0, 0,                 0, 0,      0, 0,            1, 32'h40);
    tbl[6]  = mk(1, 0, 32'h44,  0,            1, 0, 1, 32'h12345678,      0, 0,      0, 0,            0, 0);
    tbl[7]  = mk(0, 0, 32'h44,  0,            1, 0, 1, 32'h0,             0, 0,      0, 0,            0, 0);
    tbl[8]  = mk(1, 0, 32'h24,  0,            1, 2, 1, word_pat(32'h24),  0, 0,      0, 0,            1, 32'h20);
    tbl[9]  = mk(1, 0, 32'h844, 0,            1, 3, 1, word_pat(32'h844), 1, 32'h40, 1, 32'h12345678, 1, 32'h840);
    tbl[10] = mk(1, 1, 32'h848, 32'hCAFE0001, 1, 0, 0, 0,                 0, 0,      0, 0,            0, 0);
    tbl[11] = mk(1, 0, 32'h848, 0,            1, 0, 1, 32'hCAFE0001,      0, 0,      0, 0,            0, 0);
    tbl[12] = mk(1, 0, 32'h84C, 0,            1, 0, 1, word_pat(32'h84C), 0, 0,      0, 0,            0, 0);

    // reset
    rst_i       = 1'b0;
    cpu_read_i  = 1'b0;
    cpu_write_i = 1'b0;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
    mem_rdata_i = '0;
    mem_ack_i   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/stall",  {31'd0, cpu_stall_o},  32'd0);
    check("reset/enable", {31'd0, mem_enable_o}, 32'd0);
    check("reset/mwrite", {31'd0, mem_write_o},  32'd0);
    check("reset/rdata",  cpu_rdata_o,           32'd0);
    check("reset/state",  {30'd0, dbg_state_o},  32'd0);
    rst_i = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      do_access($sformatf("vec%0d", i), tbl[i]);
    end

    // stray ack while idle must be ignored
    mem_ack_i = 1'b1;
    @(posedge clk);
    #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    check("stray_ack/state",  {30'd0, dbg_state_o},  32'd0);
    check("stray_ack/enable", {31'd0, mem_enable_o}, 32'd0);
    do_access("stray_ack/hit", mk(1, 0, 32'h848, 0, 1, 0, 1, 32'hCAFE0001, 0, 0, 0, 0, 0, 0));

    // reset in the middle of a fetch
    cpu_read_i = 1'b1;
    cpu_addr_i = 32'hC64;
    @(negedge clk);
    check("rst_mid/miss_stall", {31'd0, cpu_stall_o}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid/alloc_en",   {31'd0, mem_enable_o}, 32'd1);
    check("rst_mid/alloc_wr",   {31'd0, mem_write_o},  32'd0);
    check("rst_mid/alloc_addr", mem_addr_o,            32'hC60);
    check("rst_mid/alloc_st",   {30'd0, dbg_state_o},  32'd2);
    #2;
    rst_i = 1'b0;
    #1;
    check("rst_mid/enable_drop", {31'd0, mem_enable_o}, 32'd0);
    check("rst_mid/state_idle",  {30'd0, dbg_state_o},  32'd0);
    cpu_read_i = 1'b0;
    @(posedge clk);
    #2;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    do_access("rst_mid/refetch", mk(1, 0, 32'hC64, 0, 1, 2, 1, word_pat(32'hC64), 0, 0, 0, 0, 1, 32'hC60));
    do_access("rst_mid/was_dirty", mk(1, 0, 32'h848, 0, 1, 2, 1, word_pat(32'h848), 0, 0, 0, 0, 1, 32'h840));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller for the MEM stage. It consumes the load/store request carried out of the EX/MEM pipeline register. On a miss, it raises the `MemStall` signal that freezes the ID/EX, EX/MEM and upstream pipeline registers. It exchanges whole 256-bit lines with the off-chip data memory over a request/acknowledge handshake.

## Interface
Parameters:
- None. Geometry is fixed:
  - 32 lines of 32 bytes (1 KiB total).
  - Address split: tag = addr[31:10] (22 bits), index = addr[9:5], word offset = addr[4:2].

Ports (clock and reset first):
- `clk_i` — input, 1 — single clock; all state changes on the rising edge.
- `rst_i` — input, 1 — asynchronous, active-low reset.
- `cpu_read_i` — input, 1 — load request, from EX/MEM `MemRead`.
- `cpu_write_i` — input, 1 — store request, from EX/MEM `MemWrite`.
- `cpu_addr_i` — input, 32 — byte address, word-aligned; addr[1:0] ignored.
- `cpu_wdata_i` — input, 32 — store data.
- `cpu_rdata_o` — output, 32 — load data; valid in the cycle `cpu_stall_o` is 0.
- `cpu_stall_o` — output, 1 — drives `MemStall` for all pipeline registers.
- `mem_enable_o` — output, 1 — memory request valid.
- `mem_write_o` — output, 1 — 1 = line write-back, 0 = line fetch.
- `mem_addr_o` — output, 32 — line-aligned address; [4:0] = 0.
- `mem_wdata_o` — output, 256 — victim line data.
- `mem_rdata_i` — input, 256 — fetched line data; valid when `mem_ack_i` = 1.
- `mem_ack_i` — input, 1 — one-cycle completion pulse.

## Operation
Storage:
- Per line: valid, dirty, 22-bit tag, 256-bit data.
- Word w of a line occupies bits [32w+31:32w].

Request and hit:
- req = `cpu_read_i` | `cpu_write_i`. If both are high, the access is treated as a write.
- hit = req & valid[index] & (tag[index] == addr tag).

FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: nothing happens; `cpu_stall_o` = 0.
- IDLE, read hit: `cpu_rdata_o` = the selected word, combinationally in the same cycle.
- IDLE, write hit: at the clock edge, the selected word is replaced with `cpu_wdata_i` and dirty is set to 1.
- IDLE, miss with victim valid & dirty: go to WRITEBACK.
- IDLE, any other miss: go to ALLOCATE.
- WRITEBACK:
  - `mem_enable_o` = 1, `mem_write_o` = 1.
  - `mem_addr_o` = {victim tag, index, 5'b0}; `mem_wdata_o` = victim line.
  - On `mem_ack_i`, go to ALLOCATE.
- ALLOCATE:
  - `mem_enable_o` = 1, `mem_write_o` = 0.
  - `mem_addr_o` = {request tag, index, 5'b0}.
  - On `mem_ack_i`: write `mem_rdata_i` into the line; set valid = 1, dirty = 0, tag = request tag; go to IDLE.
- After ALLOCATE, the held request hits in IDLE and completes as a normal hit. A store miss therefore merges its word into the line and sets dirty.

Stall:
- `cpu_stall_o` = (state != IDLE) | (req & ~hit), combinational.
- The CPU side holds the request stable while the stall is high; the pipeline registers freeze on `MemStall`.

Memory handshake:
- `mem_enable_o` stays high until the `mem_ack_i` cycle.
- It drops, or changes transaction type, on the following edge.
- `mem_ack_i` outside WRITEBACK/ALLOCATE is ignored.
- Idle memory-side outputs: `mem_enable_o` = 0, `mem_write_o` = 0; `mem_addr_o` and `mem_wdata_o` are don't-care but must be driven.

## Timing
Reset (`rst_i` low, asynchronous):
- state = IDLE; all valid and dirty bits = 0; tags and data are not cleared.
- Outputs: `mem_enable_o` = 0, `mem_write_o` = 0, `cpu_stall_o` = 0 (no request), `cpu_rdata_o` = 0.

Latency:
- Hit: 0 stall cycles.
- Clean miss, with ack in the N-th ALLOCATE cycle: stall for 1 + N cycles; data is returned in the next cycle.
- Dirty miss, with acks after Nw write-back cycles and Nr fetch cycles: stall for 1 + Nw + Nr cycles.

Boundary conditions:
- Reset mid-transaction: `mem_enable_o` falls immediately; the transaction is abandoned; no line is updated.
- Ack in the same cycle the FSM enters a state: not possible, because the state is entered on an edge and the ack is sampled on the next edge. A memory latency of 1 cycle (ack in the first cycle) is legal.
- Request deasserted during a miss: a protocol violation. The controller still completes the fill and returns to IDLE.
- Index conflict (same index, different tag): always evicts. There is no replacement choice.

## Test plan
- **Reset, then read miss:**
  - Stimulus: reset; read 0x0000_0024 with memory ack at latency 3.
  - Required: `cpu_stall_o` = 1 for 4 cycles; `mem_addr_o` = 0x0000_0020, `mem_write_o` = 0; data = word 1 of the fetched line.
- **Read hit:**
  - Stimulus: repeat the read of 0x0000_0024.
  - Required: stall = 0; no `mem_enable_o`; same data as before.
- **Write hit:**
  - Stimulus: write 0xDEAD_BEEF to 0x0000_0028, then read it back.
  - Required: both accesses have 0 stall cycles; readback = 0xDEAD_BEEF; dirty = 1.
- **Dirty eviction:**
  - Stimulus: read 0x0000_0428 (same index, new tag).
  - Required: WRITEBACK to 0x0000_0020 with `mem_wdata_o`[95:64] = 0xDEAD_BEEF, then ALLOCATE from 0x0000_0420; stall = 1 + Nw + Nr cycles.
- **Write miss:**
  - Stimulus: write 0x1234_5678 to 0x0000_0044 with a clean victim.
  - Required: fetch from 0x0000_0040; then the word is merged; readback = 0x1234_5678; dirty = 1.
- **Reset mid-fetch:**
  - Stimulus: pull `rst_i` low during ALLOCATE.
  - Required: `mem_enable_o` = 0 at once; state = IDLE; a subsequent read of the same address misses again.
